// File: rtl/uart_msg_sched_if.sv
// Byte-table fetch port and UART TX valid/ready port of uart_msg_sched.
// The scheduler is the master; the table + transmitter pair is the slave.
interface uart_msg_sched_if #(
    parameter int IDX_W = 4
);
    logic [IDX_W-1:0] byte_idx;
    logic [7:0]       byte_data;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;

    modport master (
        output byte_idx, tx_data, tx_valid,
        input  byte_data, tx_ready
    );

    modport slave (
        input  byte_idx, tx_data, tx_valid,
        output byte_data, tx_ready
    );
endinterface

// File: rtl/uart_msg_sched.sv
// uart_msg_sched: walks a fixed-length registered byte table into a valid/ready UART TX port.
// Optional CR/LF trailer after the last table byte when UART_SCHED_CRLF_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start, byte_idx held at 0
// FETCH  | byte_idx stable, table registers the byte
// LOAD   | capture table byte (or CR/LF) into tx_data, raise tx_valid
// SEND   | hold tx_valid until the transmitter accepts
// GAP    | idle spacing after a byte, ends with the next-byte decision
// FINISH | one-cycle done pulse, back to IDLE
module uart_msg_sched #(
    parameter int MSG_LEN    = 15,
    parameter int IDX_W      = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    uart_msg_sched_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_SEND   = 3'd3,
        S_GAP    = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);
    localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    // GAP always lasts at least one cycle: it is where the next-byte decision is taken.
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 1) ? GAP_W'(GAP_CYCLES - 1) : '0;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic [GAP_W-1:0] gap_q, gap_d;
`ifdef UART_SCHED_CRLF_EN
    logic [1:0]       tail_q, tail_d;   // 0: table bytes, 1: CR pending/sent, 2: LF
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            gap_q   <= '0;
`ifdef UART_SCHED_CRLF_EN
            tail_q  <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            gap_q   <= gap_d;
`ifdef UART_SCHED_CRLF_EN
            tail_q  <= tail_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        gap_d   = gap_q;
`ifdef UART_SCHED_CRLF_EN
        tail_d  = tail_q;
`endif
        if (abort_i) begin
            state_d = S_IDLE;
            idx_d   = '0;
            valid_d = 1'b0;
            gap_d   = '0;
`ifdef UART_SCHED_CRLF_EN
            tail_d  = 2'd0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    idx_d   = '0;
                    valid_d = 1'b0;
                    if (start_i) state_d = S_FETCH;
                end
                S_FETCH: state_d = S_LOAD;
                S_LOAD: begin
`ifdef UART_SCHED_CRLF_EN
                    case (tail_q)
                        2'd1:    data_d = 8'h0D;
                        2'd2:    data_d = 8'h0A;
                        default: data_d = bus.byte_data;
                    endcase
`else
                    data_d  = bus.byte_data;
`endif
                    valid_d = 1'b1;
                    state_d = S_SEND;
                end
                S_SEND: begin
                    if (valid_q && bus.tx_ready) begin
                        valid_d = 1'b0;
                        gap_d   = GAP_LOAD;
                        state_d = S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_q != '0) begin
                        gap_d = gap_q - GAP_W'(1);
                    end else if (idx_q == LAST_IDX) begin
`ifdef UART_SCHED_CRLF_EN
                        if (tail_q != 2'd2) begin
                            tail_d  = tail_q + 2'd1;
                            state_d = S_LOAD;
                        end else begin
                            state_d = S_FINISH;
                        end
`else
                        state_d = S_FINISH;
`endif
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_FETCH;
                    end
                end
                S_FINISH: begin
                    idx_d   = '0;
`ifdef UART_SCHED_CRLF_EN
                    tail_d  = 2'd0;
`endif
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign bus.byte_idx = idx_q;
    assign bus.tx_data  = data_q;
    assign bus.tx_valid = valid_q;
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_FINISH);

endmodule

// File: tb/tb_uart_msg_sched.sv
// Self-checking bench for uart_msg_sched: scoreboard of accepted bytes against the table contents,
// plus cycle-level timing of done, gap spacing, backpressure hold and abort/reset behaviour.
module tb_uart_msg_sched;
    localparam int MSG_LEN = 15;
    localparam int IDX_W   = 4;
`ifdef UART_SCHED_CRLF_EN
    localparam int TAIL = 2;
`else
    localparam int TAIL = 0;
`endif
    // Message length in cycles from the start-sampling edge to the done cycle.
    // Table byte: FETCH+LOAD+SEND+idle; trailer byte: LOAD+SEND+idle; idle is at least one cycle.
    localparam int IDLE0 = 1;
    localparam int IDLE1 = 3;
    localparam int CYC0  = MSG_LEN * (3 + IDLE0) + TAIL * (2 + IDLE0) + 1;
    localparam int CYC1  = MSG_LEN * (3 + IDLE1) + TAIL * (2 + IDLE1) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start0, abort0, busy0, done0;
    logic start1, abort1, busy1, done1;

    uart_msg_sched_if #(.IDX_W(IDX_W)) b0 ();
    uart_msg_sched_if #(.IDX_W(IDX_W)) b1 ();

    uart_msg_sched #(.MSG_LEN(MSG_LEN), .IDX_W(IDX_W), .GAP_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start0), .abort_i(abort0),
        .busy_o(busy0), .done_o(done0), .bus(b0.master));

    uart_msg_sched #(.MSG_LEN(MSG_LEN), .IDX_W(IDX_W), .GAP_CYCLES(3)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .abort_i(abort1),
        .busy_o(busy1), .done_o(done1), .bus(b1.master));

    logic [7:0] tbl [16];
    logic [7:0] exp_q [$];
    logic [7:0] acc0 [$];
    logic [7:0] acc1 [$];
    int         done_cnt0, done_cnt1;
    int         errors = 0;
    int         checks = 0;

    // Registered byte table shared by both schedulers.
    always @(posedge clk) begin
        b0.byte_data <= tbl[b0.byte_idx];
        b1.byte_data <= tbl[b1.byte_idx];
    end

    // Handshake monitor; inputs change 1 unit after posedge, so negedge sees the values of the next edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (b0.tx_valid && b0.tx_ready) acc0.push_back(b0.tx_data);
            if (b1.tx_valid && b1.tx_ready) acc1.push_back(b1.tx_data);
            done_cnt0 += int'(done0);
            done_cnt1 += int'(done1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic build_expected();
        exp_q.delete();
        for (int i = 0; i < MSG_LEN; i++) exp_q.push_back(tbl[i]);
        if (TAIL == 2) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic random_table();
        for (int i = 0; i < 16; i++) tbl[i] = 8'($urandom);
    endtask

    task automatic clear_scoreboard();
        acc0.delete(); acc1.delete();
        done_cnt0 = 0; done_cnt1 = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start0 = 0; abort0 = 0; start1 = 0; abort1 = 0;
        b0.tx_ready = 1'b1; b1.tx_ready = 1'b1;
        random_table();
        repeat (3) tick();
        checks++; if (busy0 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b/%b want 0", busy0, busy1); end
        checks++; if (done0 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("FAIL reset_done got %b/%b want 0", done0, done1); end
        checks++; if (b0.tx_valid !== 1'b0 || b1.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b/%b want 0", b0.tx_valid, b1.tx_valid); end
        checks++; if (b0.byte_idx !== 4'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", b0.byte_idx); end
        checks++; if (b0.tx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", b0.tx_data); end
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_full_message();
        int cyc, first_v;
        tbl = '{8'h68, 8'h69, 8'h74, 8'h73, 8'h7a, 8'h32, 8'h30, 8'h32,
                8'h34, 8'h33, 8'h31, 8'h31, 8'h32, 8'h35, 8'h20, 8'h39};
        build_expected();
        clear_scoreboard();
        b0.tx_ready = 1'b1;
        start0 = 1'b1; tick(); start0 = 1'b0;
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL full_busy_rise got %b want 1", busy0); end
        cyc = 1; first_v = 0;
        while (!done0 && cyc < 400) begin
            if (b0.tx_valid && first_v == 0) first_v = cyc;
            tick(); cyc++;
        end
        checks++; if (first_v != 3) begin errors++; $display("FAIL full_first_valid got cycle %0d want 3", first_v); end
        checks++; if (cyc != CYC0) begin errors++; $display("FAIL full_done_cycle got %0d want %0d", cyc, CYC0); end
        tick();
        checks++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("FAIL full_busy_fall got busy=%b done=%b want 0/0", busy0, done0); end
        checks++; if (done_cnt0 != 1) begin errors++; $display("FAIL full_done_pulses got %0d want 1", done_cnt0); end
        checks++;
        if (acc0.size() != exp_q.size()) begin
            errors++; $display("FAIL full_count got %0d bytes want %0d", acc0.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++)
                if (acc0[i] !== exp_q[i]) begin errors++; $display("FAIL full_byte[%0d] got %h want %h", i, acc0[i], exp_q[i]); break; end
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        bit stalled;
        random_table();
        build_expected();
        clear_scoreboard();
        b0.tx_ready = 1'b1;
        start0 = 1'b1; tick(); start0 = 1'b0;
        cyc = 1; stalled = 0;
        while (!done0 && cyc < 400) begin
            if (!stalled && b0.tx_valid && b0.byte_idx == 4'd2) begin
                stalled = 1;
                b0.tx_ready = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    tick(); cyc++;
                    checks++;
                    if (b0.tx_valid !== 1'b1 || b0.tx_data !== tbl[2] || b0.byte_idx !== 4'd2) begin
                        errors++;
                        $display("FAIL bp_hold[%0d] got valid=%b data=%h idx=%0d want 1/%h/2", k, b0.tx_valid, b0.tx_data, b0.byte_idx, tbl[2]);
                    end
                end
                b0.tx_ready = 1'b1;
            end
            tick(); cyc++;
        end
        checks++; if (!stalled || !done0) begin errors++; $display("FAIL bp_progress got stalled=%0d done=%b want 1/1", stalled, done0); end
        tick();
        checks++;
        if (acc0.size() != exp_q.size()) begin
            errors++; $display("FAIL bp_count got %0d bytes want %0d", acc0.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++)
                if (acc0[i] !== exp_q[i]) begin errors++; $display("FAIL bp_byte[%0d] got %h want %h", i, acc0[i], exp_q[i]); break; end
        end
    endtask

    task automatic test_random_ready();
        int cyc;
        for (int run = 0; run < 3; run++) begin
            random_table();
            build_expected();
            clear_scoreboard();
            start0 = 1'b1; tick(); start0 = 1'b0;
            cyc = 1;
            while (!done0 && cyc < 3000) begin
                b0.tx_ready = 1'($urandom_range(0, 1));
                tick(); cyc++;
            end
            b0.tx_ready = 1'b1;
            tick();
            checks++; if (done_cnt0 != 1) begin errors++; $display("FAIL rr_done[%0d] got %0d pulses want 1", run, done_cnt0); end
            checks++;
            if (acc0.size() != exp_q.size()) begin
                errors++; $display("FAIL rr_count[%0d] got %0d bytes want %0d", run, acc0.size(), exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++)
                    if (acc0[i] !== exp_q[i]) begin errors++; $display("FAIL rr_byte[%0d][%0d] got %h want %h", run, i, acc0[i], exp_q[i]); break; end
            end
        end
    endtask

    task automatic test_gap();
        int cyc, idle;
        logic [IDX_W-1:0] hs;
        random_table();
        build_expected();
        clear_scoreboard();
        b1.tx_ready = 1'b1;
        start1 = 1'b1; tick(); start1 = 1'b0;
        cyc = 1;
        while (!done1 && cyc < 600) begin
            if (b1.tx_valid) begin
                hs = b1.byte_idx;
                tick(); cyc++;
                idle = 0;
                while (!b1.tx_valid && !done1 && b1.byte_idx == hs && idle < 10) begin
                    idle++; tick(); cyc++;
                end
                if (hs < IDX_W'(MSG_LEN - 1)) begin
                    checks++;
                    if (idle != 3) begin errors++; $display("FAIL gap_idle[%0d] got %0d cycles want 3", hs, idle); end
                end
            end else begin
                tick(); cyc++;
            end
        end
        checks++; if (cyc != CYC1) begin errors++; $display("FAIL gap_done_cycle got %0d want %0d", cyc, CYC1); end
        tick();
        checks++;
        if (acc1.size() != exp_q.size()) begin
            errors++; $display("FAIL gap_count got %0d bytes want %0d", acc1.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++)
                if (acc1[i] !== exp_q[i]) begin errors++; $display("FAIL gap_byte[%0d] got %h want %h", i, acc1[i], exp_q[i]); break; end
        end
    endtask

    task automatic test_abort();
        int n;
        bit woke;
        random_table();
        clear_scoreboard();
        b0.tx_ready = 1'b1;
        start0 = 1'b1; tick(); start0 = 1'b0;
        n = 0;
        while (b0.byte_idx != 4'd5 && n < 200) begin tick(); n++; end
        checks++; if (n >= 200) begin errors++; $display("FAIL abort_reach5 timed out idx=%0d want 5", b0.byte_idx); end
        start0 = 1'b1; tick(); start0 = 1'b0;
        checks++; if (busy0 !== 1'b1 || b0.byte_idx !== 4'd5) begin errors++; $display("FAIL abort_start_ignored got busy=%b idx=%0d want 1/5", busy0, b0.byte_idx); end
        n = 0;
        while (b0.byte_idx != 4'd7 && n < 200) begin tick(); n++; end
        checks++; if (n >= 200) begin errors++; $display("FAIL abort_reach7 timed out idx=%0d want 7", b0.byte_idx); end
        abort0 = 1'b1; tick(); abort0 = 1'b0;
        checks++;
        if (busy0 !== 1'b0 || b0.tx_valid !== 1'b0 || b0.byte_idx !== 4'd0 || done0 !== 1'b0) begin
            errors++; $display("FAIL abort_idle got busy=%b valid=%b idx=%0d done=%b want 0/0/0/0", busy0, b0.tx_valid, b0.byte_idx, done0);
        end
        woke = 0;
        for (int k = 0; k < 30; k++) begin tick(); if (busy0) woke = 1; end
        checks++; if (woke || done_cnt0 != 0) begin errors++; $display("FAIL abort_no_restart got woke=%0d done=%0d want 0/0", woke, done_cnt0); end
        checks++; if (acc0.size() != 7) begin errors++; $display("FAIL abort_sent got %0d bytes want 7", acc0.size()); end

        // abort coinciding with a handshake: the byte still counts as taken
        clear_scoreboard();
        start0 = 1'b1; tick(); start0 = 1'b0;
        n = 0;
        while (!(b0.tx_valid && b0.byte_idx == 4'd3) && n < 200) begin tick(); n++; end
        abort0 = 1'b1; tick(); abort0 = 1'b0;
        checks++; if (busy0 !== 1'b0 || b0.tx_valid !== 1'b0) begin errors++; $display("FAIL abort_hs_idle got busy=%b valid=%b want 0/0", busy0, b0.tx_valid); end
        checks++;
        if (acc0.size() != 4 || acc0[3] !== tbl[3]) begin
            errors++; $display("FAIL abort_hs_bytes got %0d bytes want 4 ending %h", acc0.size(), tbl[3]);
        end
        // abort wins over start in IDLE
        start0 = 1'b1; abort0 = 1'b1; tick(); start0 = 1'b0; abort0 = 1'b0;
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL abort_prio got busy=%b want 0", busy0); end
        tick();
        checks++; if (done_cnt0 != 0) begin errors++; $display("FAIL abort_done got %0d pulses want 0", done_cnt0); end
    endtask

    task automatic test_reset_mid();
        int n;
        bit woke;
        random_table();
        clear_scoreboard();
        b0.tx_ready = 1'b1;
        start0 = 1'b1; tick(); start0 = 1'b0;
        n = 0;
        while (!(b0.tx_valid && b0.byte_idx == 4'd4) && n < 200) begin tick(); n++; end
        b0.tx_ready = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (busy0 !== 1'b0 || b0.tx_valid !== 1'b0 || b0.byte_idx !== 4'd0 || b0.tx_data !== 8'h00 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got busy=%b valid=%b idx=%0d data=%h done=%b want 0/0/0/00/0", busy0, b0.tx_valid, b0.byte_idx, b0.tx_data, done0);
        end
        tick();
        rst_n = 1'b1;
        b0.tx_ready = 1'b1;
        woke = 0;
        for (int k = 0; k < 20; k++) begin tick(); if (busy0 || b0.tx_valid) woke = 1; end
        checks++; if (woke || done_cnt0 != 0) begin errors++; $display("FAIL reset_quiet got woke=%0d done=%0d want 0/0", woke, done_cnt0); end
    endtask

    initial begin
        test_reset();
        test_full_message();
        test_backpressure();
        test_random_ready();
        test_gap();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
